cplx_mm_sequencer: RTL

//  - Sequences one complex matrix product C = A*B, DIM x DIM, one output element at a time, row-major.
//  - Runs two passes per element: REAL (ArBr - AiBi), then IMAG (ArBi + AiBr, crossed operands).
//  - Drives the operand block-select state, row/col indices and a valid/ready handshake to the MAC.
//  - Issues the write strobe for each finished real or imaginary result.

---
 rtl/cplx_mm_sequencer_pkg.sv | 28 ++
 rtl/cplx_mm_idx_cnt.sv | 28 ++
 rtl/cplx_mm_sequencer.sv | 73 +++++++
 3 files changed

// File: rtl/cplx_mm_sequencer_pkg.sv
// cplx_mm_sequencer_pkg: shared constants, FSM encodings and index type for the complex matmul sequencer
`ifndef CPLX_MM_MACRO_V
`define CPLX_MM_MACRO_V
`define WORD_LEN 16
`ifndef MATRIX_DIM
`define MATRIX_DIM 2
`endif
`define REAL_SET 1'b1
`define IMAG_SET (~`REAL_SET)
`define ST_IDLE 3'd0
`define ST_ISSUE 3'd1
`define ST_WAIT 3'd2
`define ST_WRITE 3'd3
`define ST_DONE 3'd4
`endif
package cplx_mm_sequencer_pkg;
  localparam int DIM = `MATRIX_DIM;
  localparam int IDX_W = (DIM > 2) ? $clog2(DIM) : 1;
  typedef logic [IDX_W-1:0] idx_t;
  localparam idx_t IDX_LAST = idx_t'(DIM - 1);
  localparam logic REAL_SET = `REAL_SET;
  localparam logic IMAG_SET = `IMAG_SET;
  localparam logic [2:0] S_IDLE = `ST_IDLE;
  localparam logic [2:0] S_ISSUE = `ST_ISSUE;
  localparam logic [2:0] S_WAIT = `ST_WAIT;
  localparam logic [2:0] S_WRITE = `ST_WRITE;
  localparam logic [2:0] S_DONE = `ST_DONE;
endpackage

// File: rtl/cplx_mm_idx_cnt.sv
// cplx_mm_idx_cnt: row-major row/col element counter with last-element flag
module cplx_mm_idx_cnt
  import cplx_mm_sequencer_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_adv,
  output idx_t o_row,
  output idx_t o_col,
  output logic o_last
);
  idx_t r_row, r_col;
  logic w_wrap;
  assign w_wrap = r_col == IDX_LAST;
  assign o_last = (r_row == IDX_LAST) && w_wrap;
  assign o_row = r_row;
  assign o_col = r_col;
  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_row <= '0;
      r_col <= '0;
    end else if (i_adv && !o_last) begin
      r_col <= w_wrap ? '0 : r_col + 1'b1;
      r_row <= w_wrap ? r_row + 1'b1 : r_row;
    end
  end
endmodule

// File: rtl/cplx_mm_sequencer.sv
// cplx_mm_sequencer: REAL/IMAG two-pass sequencer for C=A*B; CPLX_MM_PERF_CNT_EN adds cycle_cnt
module cplx_mm_sequencer
  import cplx_mm_sequencer_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic abort,
  output logic busy,
  output logic done,
  output logic sel_state,
  output idx_t row_idx,
  output idx_t col_idx,
  output logic mac_valid,
  input  logic mac_ready,
  output logic mac_sub,
  input  logic mac_done,
  output logic wr_en,
  output logic wr_part
`ifdef CPLX_MM_PERF_CNT_EN
  , output logic [31:0] cycle_cnt
`endif
);
  logic [2:0] r_state, w_nstate;
  logic r_sel, w_nsel;
  logic w_start, w_clr, w_adv, w_last;
  always_comb begin
    w_start = (r_state == S_IDLE) && start && !abort;
    w_clr = abort || w_start;
    w_adv = (r_state == S_WRITE) && (r_sel == IMAG_SET) && !abort;
    w_nstate = abort ? S_IDLE :
               (r_state == S_IDLE) ? (start ? S_ISSUE : S_IDLE) :
               (r_state == S_ISSUE) ? (mac_ready ? S_WAIT : S_ISSUE) :
               (r_state == S_WAIT) ? (mac_done ? S_WRITE : S_WAIT) :
               (r_state == S_WRITE) ? ((r_sel == IMAG_SET && w_last) ? S_DONE : S_ISSUE) :
               S_IDLE;
    w_nsel = w_clr ? REAL_SET : (r_state == S_WRITE) ? ~r_sel : r_sel;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_sel <= REAL_SET;
    end else begin
      r_state <= w_nstate;
      r_sel <= w_nsel;
    end
  end
  cplx_mm_idx_cnt u_idx (
    .clk(clk),
    .rst(rst),
    .i_clr(w_clr),
    .i_adv(w_adv),
    .o_row(row_idx),
    .o_col(col_idx),
    .o_last(w_last)
  );
  assign busy = (r_state == S_ISSUE) || (r_state == S_WAIT) || (r_state == S_WRITE);
  assign done = (r_state == S_DONE) && !abort && !rst;
  assign wr_en = (r_state == S_WRITE) && !abort && !rst;
  assign wr_part = wr_en ? r_sel : 1'b0;
  assign sel_state = r_sel;
  assign mac_valid = r_state == S_ISSUE;
  assign mac_sub = mac_valid && (r_sel == REAL_SET);
`ifdef CPLX_MM_PERF_CNT_EN
  logic [31:0] r_cnt;
  always_ff @(posedge clk) begin
    if (rst) r_cnt <= '0;
    else if (w_start) r_cnt <= 32'd1;
    else if (busy && !(&r_cnt)) r_cnt <= r_cnt + 32'd1;
  end
  assign cycle_cnt = r_cnt;
`endif
endmodule
